// File: rtl/control_calcu.sv
// Calculator sequencer: walks operand entry (A, B), launches the selected unit,
// waits for completion or timeout, and holds the result or error for display.
module control_calcu #(
    parameter int SUM_LAT = 1,
    parameter int TMO     = 1023,
    parameter int TMO_W   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       enter,
    input  logic       op_wr,
    input  logic [2:0] op_in,
    input  logic       done,
    input  logic       cout,
    input  logic       b_zero,
    output logic [1:0] estado,
    output logic [2:0] OP,
    output logic       ld_a,
    output logic       ld_b,
    output logic       start,
    output logic       busy,
    output logic       res_vld,
    output logic       ovf,
    output logic       err
);

    // Counter must hold both the adder latency (up to 15) and the timeout limit.
    localparam int CW = (TMO_W > 4) ? TMO_W : 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A     = 3'd1,
        S_B     = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_SHOW  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_estado;
    logic [2:0]      r_op;
    logic            r_ld_a;
    logic            r_ld_b;
    logic            r_start;
    logic            r_busy;
    logic            r_res_vld;
    logic            r_ovf;
    logic            r_err;

    state_t          w_nxt;
    logic [2:0]      w_op_nxt;
    logic            w_ld_a;
    logic            w_ld_b;
    logic            w_sum_op;
    logic            w_wait_exit;
    logic            w_tmo_hit;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'b100);
    endfunction

    function automatic logic [1:0] estado_of(input state_t st);
        case (st)
            S_IDLE:  return 2'b00;
            S_A:     return 2'b01;
            S_B:     return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Next-state, operation latch and load-strobe decode.
    always_comb begin
        w_nxt       = r_state;
        w_op_nxt    = r_op;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_sum_op    = (r_op[2:1] == 2'b00);
        w_wait_exit = w_sum_op ? (r_cnt == CW'(SUM_LAT - 1)) : done;
        w_tmo_hit   = (TMO != 0) && (r_cnt == CW'(TMO - 1));
        case (r_state)
            S_IDLE: begin
                w_nxt = S_A;
            end
            S_A: begin
                if (clr) begin
                    w_nxt = S_A;
                end else begin
                    if (op_wr && op_legal(op_in)) begin
                        w_op_nxt = op_in;
                    end else begin
                        w_op_nxt = r_op;
                    end
                    if (enter) begin
                        w_ld_a = 1'b1;
                        w_nxt  = w_op_nxt[2] ? S_START : S_B;
                    end else begin
                        w_nxt = S_A;
                    end
                end
            end
            S_B: begin
                if (clr) begin
                    w_nxt = S_A;
                end else begin
                    // raiz is unary, so it cannot be selected once B entry has begun
                    if (op_wr && op_legal(op_in) && (op_in != 3'b100)) begin
                        w_op_nxt = op_in;
                    end else begin
                        w_op_nxt = r_op;
                    end
                    if (enter) begin
                        w_ld_b = 1'b1;
                        w_nxt  = ((w_op_nxt == 3'b011) && b_zero) ? S_ERR : S_START;
                    end else begin
                        w_nxt = S_B;
                    end
                end
            end
            S_START: begin
                w_nxt = clr ? S_A : S_WAIT;
            end
            S_WAIT: begin
                if (clr) begin
                    w_nxt = S_A;
                end else if (w_wait_exit) begin
                    w_nxt = S_SHOW;
                end else if (w_tmo_hit) begin
                    w_nxt = S_ERR;
                end else begin
                    w_nxt = S_WAIT;
                end
            end
            S_SHOW, S_ERR: begin
                if (enter || clr) begin
                    w_nxt = S_A;
                end else begin
                    w_nxt = r_state;
                end
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
    end

    // State, WAIT counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_estado  <= 2'b00;
            r_op      <= 3'b000;
            r_ld_a    <= 1'b0;
            r_ld_b    <= 1'b0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_res_vld <= 1'b0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_estado  <= estado_of(w_nxt);
            r_op      <= w_op_nxt;
            r_ld_a    <= w_ld_a;
            r_ld_b    <= w_ld_b;
            r_start   <= (w_nxt == S_START);
            r_busy    <= (w_nxt == S_START) || (w_nxt == S_WAIT);
            r_res_vld <= (w_nxt == S_SHOW);
            r_err     <= (w_nxt == S_ERR);
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == S_WAIT) && (w_nxt == S_SHOW) && w_sum_op) begin
                r_ovf <= cout;
            end else if (w_nxt != S_SHOW) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign estado  = r_estado;
    assign OP      = r_op;
    assign ld_a    = r_ld_a;
    assign ld_b    = r_ld_b;
    assign start   = r_start;
    assign busy    = r_busy;
    assign res_vld = r_res_vld;
    assign ovf     = r_ovf;
    assign err     = r_err;

endmodule
